// File: rtl/ysyx_22041752_booth_mul_if.sv
// Request/response bundle between the execute stage and the Booth multiplier.
// master = pipeline side, slave = multiplier side.
interface ysyx_22041752_booth_mul_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic             mul_u;
   logic             mul_su;
   logic             mul_h;
   logic             mul_w;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] product;
   logic             busy;

   modport master (
      output in_valid, mul_u, mul_su, mul_h, mul_w, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, mul_u, mul_su, mul_h, mul_w, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/ysyx_22041752_booth_mul.sv
// Iterative radix-4 Booth multiplier for RV64M MUL/MULH/MULHSU/MULHU and MULW.
// Two multiplier bits are retired per cycle by shifting the {acc, mreg} pair right by 2.
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | waiting for a request, in_ready=1
//   CALC  | one Booth step per cycle, cnt_q counts down
//   DONE  | product presented, held until out_ready
module ysyx_22041752_booth_mul #(
   parameter int WIDTH     = 64,
   parameter int SUPPORT_W = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   ysyx_22041752_booth_mul_if.slave mul_if
);

   localparam int XW     = WIDTH + 2;
   localparam int AW     = XW + 2;
   localparam int MW     = XW + 1;
   localparam int RW     = AW + MW;
   localparam int ITER   = XW / 2;
   localparam int ITER_W = 17;
   localparam int CW     = $clog2((ITER > ITER_W) ? ITER : ITER_W);
   localparam logic [CW-1:0] LAST_FULL = CW'(ITER - 1);
   localparam logic [CW-1:0] LAST_WORD = CW'(ITER_W - 1);
   localparam bit HAS_W = (SUPPORT_W != 0) && (WIDTH == 64);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [XW-1:0]    a_q, a_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [MW-1:0]    mreg_q, mreg_d;
   logic             h_q, h_d;
   logic             w_q, w_d;
   logic [WIDTH-1:0] product_q, product_d;

   logic             a_sgn, b_sgn;
   logic [XW-1:0]    a_full, b_full, a_word, b_word;
   logic             zero_full, zero_word, w_req;
   logic [AW-1:0]    booth_mag, booth_term, acc_sum;
   logic             booth_neg;
   logic [RW-1:0]    pair_sh;
   logic [WIDTH-1:0] prod_full, prod_word;

   assign a_sgn     = ~mul_if.mul_u;
   assign b_sgn     = ~(mul_if.mul_u | mul_if.mul_su);
   assign a_full    = {{2{a_sgn & mul_if.multiplicand[WIDTH-1]}}, mul_if.multiplicand};
   assign b_full    = {{2{b_sgn & mul_if.multiplier[WIDTH-1]}}, mul_if.multiplier};
   assign zero_full = (mul_if.multiplicand == '0) || (mul_if.multiplier == '0);

   generate
      if (HAS_W) begin : g_word
         assign w_req     = mul_if.mul_w;
         assign a_word    = {{(XW-32){mul_if.multiplicand[31]}}, mul_if.multiplicand[31:0]};
         assign b_word    = {{(XW-32){mul_if.multiplier[31]}}, mul_if.multiplier[31:0]};
         assign zero_word = (mul_if.multiplicand[31:0] == 32'd0) ||
                            (mul_if.multiplier[31:0] == 32'd0);
         // After 17 steps the 32-bit product sits at bit WIDTH-31 of the shifted pair;
         // the sign bits of B left below it never overlap the product.
         assign prod_word = {{(WIDTH-32){pair_sh[WIDTH]}}, pair_sh[WIDTH:WIDTH-31]};
      end else begin : g_no_word
         assign w_req     = 1'b0;
         assign a_word    = '0;
         assign b_word    = '0;
         assign zero_word = 1'b0;
         assign prod_word = '0;
      end
   endgenerate

   always_comb begin
      booth_mag = '0;
      booth_neg = 1'b0;
      case (mreg_q[2:0])
         3'b001, 3'b010: booth_mag = {{2{a_q[XW-1]}}, a_q};
         3'b011:         booth_mag = {a_q[XW-1], a_q, 1'b0};
         3'b100: begin
            booth_mag = {a_q[XW-1], a_q, 1'b0};
            booth_neg = 1'b1;
         end
         3'b101, 3'b110: begin
            booth_mag = {{2{a_q[XW-1]}}, a_q};
            booth_neg = 1'b1;
         end
         default: ;
      endcase
   end

   assign booth_term = booth_mag ^ {AW{booth_neg}};
   assign acc_sum    = acc_q + booth_term + AW'(booth_neg);
   assign pair_sh    = {{2{acc_sum[AW-1]}}, acc_sum, mreg_q[MW-1:2]};
   // Full-width pair holds 2*A*B, so the 2W-bit product starts at bit 1.
   assign prod_full  = h_q ? pair_sh[2*WIDTH:WIDTH+1] : pair_sh[WIDTH:1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      acc_d     = acc_q;
      mreg_d    = mreg_q;
      h_d       = h_q;
      w_d       = w_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (mul_if.in_valid && !flush) begin
               a_d = w_req ? a_word : a_full;
               h_d = mul_if.mul_h;
               w_d = w_req;
               if (w_req ? zero_word : zero_full) begin
                  state_d   = DONE;
                  product_d = '0;
               end else begin
                  state_d = CALC;
                  acc_d   = '0;
                  mreg_d  = {(w_req ? b_word : b_full), 1'b0};
                  cnt_d   = w_req ? LAST_WORD : LAST_FULL;
               end
            end
         end
         CALC: begin
            acc_d  = pair_sh[RW-1:MW];
            mreg_d = pair_sh[MW-1:0];
            if (cnt_q == '0) begin
               state_d   = DONE;
               product_d = w_q ? prod_word : prod_full;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (mul_if.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         acc_q     <= '0;
         mreg_q    <= '0;
         h_q       <= 1'b0;
         w_q       <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         acc_q     <= acc_d;
         mreg_q    <= mreg_d;
         h_q       <= h_d;
         w_q       <= w_d;
         product_q <= product_d;
      end
   end

   assign mul_if.in_ready  = (state_q == IDLE);
   assign mul_if.out_valid = (state_q == DONE);
   assign mul_if.busy      = (state_q != IDLE);
   assign mul_if.product   = product_q;

endmodule

// File: tb/tb_ysyx_22041752_booth_mul.sv
// Directed and randomised checks of the radix-4 Booth multiplier against a plain
// 130-bit arithmetic reference.
module tb_ysyx_22041752_booth_mul;

   logic clk;
   logic reset;
   logic flush;
   int   checks;
   int   failures;

   ysyx_22041752_booth_mul_if #(.WIDTH(64)) mif ();

   ysyx_22041752_booth_mul #(.WIDTH(64), .SUPPORT_W(1)) dut (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .mul_if (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input bit u, input bit su, input bit h, input bit w);
      logic signed [129:0] ax, bx, p;
      logic signed [63:0]  pw;
      if (w) begin
         pw = $signed({{32{a[31]}}, a[31:0]}) * $signed({{32{b[31]}}, b[31:0]});
         return {{32{pw[31]}}, pw[31:0]};
      end
      ax = u ? {66'd0, a} : {{66{a[63]}}, a};
      bx = (u || su) ? {66'd0, b} : {{66{b[63]}}, b};
      p  = ax * bx;
      return h ? p[127:64] : p[63:0];
   endfunction

   // Called #1 after an edge with the unit idle and out_ready low.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input bit u, input bit su, input bit h, input bit w,
                         input logic [63:0] exp, input int exp_lat, input int hold);
      int lat;
      mif.multiplicand = a;
      mif.multiplier   = b;
      mif.mul_u        = u;
      mif.mul_su       = su;
      mif.mul_h        = h;
      mif.mul_w        = w;
      mif.in_valid     = 1'b1;
      @(posedge clk); #1;
      mif.in_valid     = 1'b0;
      mif.multiplicand = {$urandom, $urandom};
      mif.multiplier   = {$urandom, $urandom};
      mif.mul_u        = 1'($urandom_range(0, 1));
      mif.mul_su       = 1'($urandom_range(0, 1));
      mif.mul_h        = 1'($urandom_range(0, 1));
      mif.mul_w        = 1'($urandom_range(0, 1));
      lat = 1;
      while (!mif.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " product"}, mif.product, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, " hold valid/ready"}, {62'd0, mif.out_valid, mif.in_ready}, 64'h2);
         check({tag, " hold product"}, mif.product, exp);
      end
      mif.out_ready = 1'b1;
      @(posedge clk); #1;
      mif.out_ready = 1'b0;
      check({tag, " drain valid/ready"}, {62'd0, mif.out_valid, mif.in_ready}, 64'h1);
   endtask

   initial begin
      logic [63:0] a, b, exp;
      bit          u, su, h, w, zero, seen;
      int          mode, sel, lat;

      checks           = 0;
      failures         = 0;
      reset            = 1'b1;
      flush            = 1'b0;
      mif.in_valid     = 1'b0;
      mif.out_ready    = 1'b0;
      mif.mul_u        = 1'b0;
      mif.mul_su       = 1'b0;
      mif.mul_h        = 1'b0;
      mif.mul_w        = 1'b0;
      mif.multiplicand = '0;
      mif.multiplier   = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("reset out_valid", 64'(mif.out_valid), 64'd0);
      check("reset product", mif.product, 64'd0);
      check("reset busy", 64'(mif.busy), 64'd0);
      check("reset in_ready", 64'(mif.in_ready), 64'd1);

      run_op("mul 3*-5", 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 0, 0,
             64'hFFFF_FFFF_FFFF_FFF1, 34, 0);
      run_op("mulhu ones", '1, '1, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
      run_op("mulh ones", '1, '1, 0, 0, 1, 0, 64'h0, 34, 0);
      run_op("mulhsu ones", '1, '1, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
      run_op("mulsu low ones", '1, '1, 0, 1, 0, 0, 64'h1, 34, 0);
      run_op("mulw max*2", 64'h7FFF_FFFF, 64'd2, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 18, 0);
      run_op("mulw ignores upper/mode", 64'hDEAD_0000_7FFF_FFFF, 64'h1234_5678_0000_0002,
             1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 18, 0);

      // reset in the middle of a calculation
      mif.multiplicand = 64'd3;
      mif.multiplier   = 64'd5;
      mif.mul_u = 0; mif.mul_su = 0; mif.mul_h = 0; mif.mul_w = 0;
      mif.in_valid     = 1'b1;
      @(posedge clk); #1;
      mif.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid reset busy/valid/ready", {61'd0, mif.busy, mif.out_valid, mif.in_ready}, 64'h1);
      check("mid reset product", mif.product, 64'd0);

      run_op("zero early-out", 64'd0, 64'h1234, 0, 0, 0, 0, 64'd0, 1, 5);
      run_op("mulw zero low word", 64'hFFFF_FFFF_0000_0000, 64'd7, 0, 0, 0, 1, 64'd0, 1, 0);
      run_op("backpressure", 64'h1234_5678, 64'h1000, 0, 0, 0, 0,
             64'h0000_0123_4567_8000, 34, 5);

      // flush in CALC after ten steps
      mif.multiplicand = 64'd5;
      mif.multiplier   = 64'd7;
      mif.mul_u = 0; mif.mul_su = 0; mif.mul_h = 0; mif.mul_w = 0;
      mif.in_valid     = 1'b1;
      @(posedge clk); #1;
      mif.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("flush calc busy before", 64'(mif.busy), 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush calc busy/valid/ready", {61'd0, mif.busy, mif.out_valid, mif.in_ready}, 64'h1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (mif.out_valid) seen = 1'b1;
      end
      check("flush calc no out_valid", 64'(seen), 64'd0);

      // flush together with a request in IDLE
      mif.multiplicand = 64'd3;
      mif.multiplier   = 64'd4;
      mif.in_valid     = 1'b1;
      flush            = 1'b1;
      @(posedge clk); #1;
      mif.in_valid = 1'b0;
      flush        = 1'b0;
      check("flush accept busy", 64'(mif.busy), 64'd0);
      @(posedge clk); #1;
      check("flush accept later busy/valid", {62'd0, mif.busy, mif.out_valid}, 64'd0);

      // flush in DONE while out_ready is high
      mif.multiplicand = 64'd0;
      mif.multiplier   = 64'd9;
      mif.in_valid     = 1'b1;
      @(posedge clk); #1;
      mif.in_valid = 1'b0;
      check("flush done valid before", 64'(mif.out_valid), 64'd1);
      mif.out_ready = 1'b1;
      flush         = 1'b1;
      @(posedge clk); #1;
      mif.out_ready = 1'b0;
      flush         = 1'b0;
      check("flush done valid/ready", {62'd0, mif.out_valid, mif.in_ready}, 64'h1);

      for (int i = 0; i < 1000 && failures < 20; i++) begin
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         sel = $urandom_range(0, 15);
         if (sel == 0) a = '0;
         else if (sel == 1) b = '0;
         else if (sel == 2) a = 64'h8000_0000_0000_0000;
         else if (sel == 3) b = '1;
         else if (sel == 4) a = {32'hFFFF_FFFF, 32'h0};
         mode = $urandom_range(0, 4);
         w    = (mode == 4);
         u    = (mode == 3);
         su   = (mode == 2);
         h    = (mode == 1) || (mode == 2) || (mode == 3);
         if (w) begin
            u  = 1'($urandom_range(0, 1));
            su = 1'($urandom_range(0, 1));
            h  = 1'($urandom_range(0, 1));
         end else if (mode == 0) begin
            h = 1'($urandom_range(0, 1));
         end
         exp  = ref_mul(a, b, u, su, h, w);
         zero = w ? ((a[31:0] == 32'd0) || (b[31:0] == 32'd0)) : ((a == 64'd0) || (b == 64'd0));
         lat  = zero ? 1 : (w ? 18 : 34);
         run_op("random", a, b, u, su, h, w, exp, lat, $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
